// File: rtl/keylock_pkg.sv
// Shared definitions for the keypad lock: key codes, FSM state encoding and
// small sizing helpers used by the lock core and its code bank.
package keylock_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_CHECK,
      ST_PROG_NEW,
      ST_PROG_CONFIRM,
      ST_LOCKOUT
   } state_e;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

   // Index width that stays legal for a single-entry table.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/code_bank.sv
// User code storage: SLOTS registers with valid bits, indexed read for the
// sequential scan, parallel presence check and a lowest-free/round-robin write.
module code_bank
   import keylock_pkg::*;
#(
   parameter int SLOTS = 4,
   parameter int CW    = 24,
   localparam int IW   = idx_width(SLOTS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [IW-1:0] rd_idx_i,
   output logic [CW-1:0] rd_code_o,
   output logic          rd_valid_o,
   input  logic [CW-1:0] query_i,
   output logic          present_o,
   input  logic          wr_en_i,
   input  logic [CW-1:0] wr_data_i
);

   logic [CW-1:0]    code_q [SLOTS];
   logic [SLOTS-1:0] valid_q;
   logic [IW-1:0]    rr_q;
   logic [IW-1:0]    free_idx;
   logic             free_found;
   logic [IW-1:0]    wr_idx;

   assign rd_code_o  = code_q[rd_idx_i];
   assign rd_valid_o = valid_q[rd_idx_i];

   always_comb begin
      present_o  = 1'b0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (valid_q[i] && (code_q[i] == query_i)) present_o = 1'b1;
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
      wr_idx = free_found ? free_idx : rr_q;
   end

   // NOTE: the code array is reset too, so a reset really forgets every enrolled
   // code instead of only dropping the valid bits over stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         rr_q    <= '0;
         for (int i = 0; i < SLOTS; i++) code_q[i] <= '0;
      end else if (wr_en_i) begin
         code_q[wr_idx]  <= wr_data_i;
         valid_q[wr_idx] <= 1'b1;
         if (!free_found) rr_q <= (rr_q == IW'(SLOTS - 1)) ? '0 : rr_q + IW'(1);
      end
   end

endmodule

// File: rtl/multi_code_lock.sv
// Keypad lock core: collects BCD digits, scans master plus user slots at a fixed
// latency, toggles the lock, handles two-step enrolment and attempt lockout.
module multi_code_lock
   import keylock_pkg::*;
#(
   parameter int DIGITS      = 6,
   parameter int SLOTS       = 4,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT_CYC = 36000000,
   parameter logic [4*DIGITS-1:0] MASTER = 24'h555116
) (
   input  logic       hwclk,
   input  logic       resetN,
   input  logic [3:0] key,
   input  logic       key_valid,
   output logic       locked,
   output logic       pass,
   output logic       fail,
   output logic       prog_mode,
   output logic       lockout,
   output logic       busy,
   output logic [3:0] n_digits
);

   localparam int CW = DIGIT_W * DIGITS;
   localparam int SW = $clog2(SLOTS + 1);
   localparam int IW = idx_width(SLOTS);
   localparam int LW = $clog2(LOCKOUT_CYC + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] buf_q, buf_d;
   logic [CW-1:0] cand_q, cand_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [3:0]    fails_q, fails_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic [SW-1:0] scan_q, scan_d;
   logic          hit_m_q, hit_m_d, hit_s_q, hit_s_d;
   logic          locked_q, locked_d, pass_q, pass_d, fail_q, fail_d;

   logic [CW-1:0] rd_code;
   logic          rd_valid, present, wr_en;
   logic [3:0]    fail_next;
   logic          in_prog, m_now, s_now;

   code_bank #(.SLOTS(SLOTS), .CW(CW)) u_bank (
      .clk        (hwclk),
      .rst_n      (resetN),
      .rd_idx_i   (IW'(scan_q - SW'(1))),
      .rd_code_o  (rd_code),
      .rd_valid_o (rd_valid),
      .query_i    (cand_q),
      .present_o  (present),
      .wr_en_i    (wr_en),
      .wr_data_i  (cand_q)
   );

   assign fail_next = fails_q + 4'd1;
   assign in_prog   = (state_q == ST_PROG_NEW) || (state_q == ST_PROG_CONFIRM);
   // Scan index 0 is the master code; index i>0 reads slot i-1.
   assign m_now = hit_m_q || ((scan_q == '0) && (buf_q == MASTER));
   assign s_now = hit_s_q || ((scan_q != '0) && rd_valid && (rd_code == buf_q));

   // NOTE: every next-state signal gets a default before the case so no path
   // leaves one unassigned and infers a latch.
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      fails_d    = fails_q;
      lock_cnt_d = lock_cnt_q;
      scan_d     = scan_q;
      hit_m_d    = hit_m_q;
      hit_s_d    = hit_s_q;
      locked_d   = locked_q;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      wr_en      = 1'b0;
      case (state_q)
         ST_CHECK: begin
            scan_d  = scan_q + SW'(1);
            hit_m_d = m_now;
            hit_s_d = s_now;
            if (scan_q == SW'(SLOTS)) begin
               buf_d   = '0;
               scan_d  = '0;
               hit_m_d = 1'b0;
               hit_s_d = 1'b0;
               state_d = ST_IDLE;
               if (m_now) begin
                  state_d = ST_PROG_NEW;
                  fails_d = '0;
               end else if (s_now) begin
                  pass_d   = 1'b1;
                  locked_d = ~locked_q;
                  fails_d  = '0;
               end else begin
                  fail_d  = 1'b1;
                  fails_d = fail_next;
                  if (fail_next == 4'(MAX_FAIL)) begin
                     state_d    = ST_LOCKOUT;
                     lock_cnt_d = LW'(LOCKOUT_CYC - 1);
                  end
               end
            end
         end
         ST_LOCKOUT: begin
            if (lock_cnt_q == '0) begin
               state_d = ST_IDLE;
               fails_d = '0;
               buf_d   = '0;
               cnt_d   = '0;
            end else begin
               lock_cnt_d = lock_cnt_q - LW'(1);
            end
         end
         ST_IDLE, ST_ENTRY, ST_PROG_NEW, ST_PROG_CONFIRM: begin
            if (key_valid && is_digit(key)) begin
               buf_d = (buf_q << DIGIT_W) | CW'(key);
               cnt_d = (cnt_q == 4'(DIGITS + 1)) ? cnt_q : cnt_q + 4'd1;
               if (state_q == ST_IDLE) state_d = ST_ENTRY;
            end else if (key_valid && (key == KEY_STAR)) begin
               buf_d = '0;
               cnt_d = '0;
            end else if (key_valid && (key == KEY_HASH)) begin
               cnt_d = '0;
               if (cnt_q != 4'(DIGITS)) begin
                  buf_d   = '0;
                  fail_d  = 1'b1;
                  state_d = ST_IDLE;
                  if (!in_prog) begin
                     fails_d = fail_next;
                     if (fail_next == 4'(MAX_FAIL)) begin
                        state_d    = ST_LOCKOUT;
                        lock_cnt_d = LW'(LOCKOUT_CYC - 1);
                     end
                  end
               end else if (state_q == ST_PROG_NEW) begin
                  buf_d = '0;
                  if (buf_q == MASTER) begin
                     fail_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     cand_d  = buf_q;
                     state_d = ST_PROG_CONFIRM;
                  end
               end else if (state_q == ST_PROG_CONFIRM) begin
                  buf_d   = '0;
                  state_d = ST_IDLE;
                  if (buf_q == cand_q) begin
                     pass_d = 1'b1;
                     wr_en  = !present;
                  end else begin
                     fail_d = 1'b1;
                  end
               end else begin
                  state_d = ST_CHECK;
                  scan_d  = '0;
                  hit_m_d = 1'b0;
                  hit_s_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge hwclk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= ST_IDLE;
         buf_q      <= '0;
         cand_q     <= '0;
         cnt_q      <= '0;
         fails_q    <= '0;
         lock_cnt_q <= '0;
         scan_q     <= '0;
         hit_m_q    <= 1'b0;
         hit_s_q    <= 1'b0;
         locked_q   <= 1'b1;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         fails_q    <= fails_d;
         lock_cnt_q <= lock_cnt_d;
         scan_q     <= scan_d;
         hit_m_q    <= hit_m_d;
         hit_s_q    <= hit_s_d;
         locked_q   <= locked_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
      end
   end

   assign locked    = locked_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign prog_mode = in_prog;
   assign lockout   = (state_q == ST_LOCKOUT);
   assign busy      = (state_q == ST_CHECK);
   assign n_digits  = cnt_q;

endmodule

// File: tb/tb_multi_code_lock.sv
// Scoreboarded bench for multi_code_lock: a behavioural lock model queues the
// expected response of every '#' and the monitor window compares against it.
module tb_multi_code_lock;
   import keylock_pkg::*;

   localparam int DIGITS      = 6;
   localparam int SLOTS       = 4;
   localparam int MAX_FAIL    = 3;
   localparam int LOCKOUT_CYC = 40;
   localparam logic [23:0] MASTER = 24'h555116;

   logic       hwclk = 1'b0;
   logic       resetN = 1'b0;
   logic [3:0] key = 4'd0;
   logic       key_valid = 1'b0;
   logic       locked, pass, fail, prog_mode, lockout, busy;
   logic [3:0] n_digits;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string name;
      int    lat;
      int    busy_n;
      logic  p;
      logic  f;
      logic  lk;
      logic  pm_before;
      logic  pm_after;
      logic  lo;
   } exp_t;

   exp_t exp_q[$];

   logic [23:0] m_buf, m_cand;
   logic [23:0] m_slot [SLOTS];
   logic        m_valid [SLOTS];
   int          m_cnt, m_rr, m_fails, m_prog;
   logic        m_locked;

   multi_code_lock #(
      .DIGITS(DIGITS), .SLOTS(SLOTS), .MAX_FAIL(MAX_FAIL),
      .LOCKOUT_CYC(LOCKOUT_CYC), .MASTER(MASTER)
   ) dut (
      .hwclk(hwclk), .resetN(resetN), .key(key), .key_valid(key_valid),
      .locked(locked), .pass(pass), .fail(fail), .prog_mode(prog_mode),
      .lockout(lockout), .busy(busy), .n_digits(n_digits)
   );

   always #5 hwclk = ~hwclk;

   task automatic model_reset();
      m_buf = '0; m_cand = '0; m_cnt = 0; m_rr = 0; m_fails = 0; m_prog = 0;
      m_locked = 1'b1;
      for (int i = 0; i < SLOTS; i++) begin
         m_slot[i] = '0;
         m_valid[i] = 1'b0;
      end
   endtask

   task automatic count_fail(output logic lo);
      lo = 1'b0;
      m_fails++;
      if (m_fails == MAX_FAIL) begin
         lo = 1'b1;
         m_fails = 0;
      end
   endtask

   task automatic model_store();
      bit done = 0;
      for (int i = 0; i < SLOTS; i++)
         if (m_valid[i] && m_slot[i] == m_cand) done = 1;
      for (int i = 0; i < SLOTS; i++)
         if (!done && !m_valid[i]) begin
            m_slot[i] = m_cand; m_valid[i] = 1'b1; done = 1;
         end
      if (!done) begin
         m_slot[m_rr] = m_cand; m_valid[m_rr] = 1'b1;
         m_rr = (m_rr + 1) % SLOTS;
      end
   endtask

   task automatic model_hash(input string name);
      exp_t e;
      bit   hit = 0;
      e.name = name; e.lat = 1; e.busy_n = 0;
      e.p = 1'b0; e.f = 1'b0; e.lo = 1'b0;
      e.pm_before = (m_prog != 0);
      if (m_cnt != DIGITS) begin
         e.f = 1'b1;
         if (m_prog != 0) m_prog = 0;
         else count_fail(e.lo);
      end else if (m_prog == 1) begin
         if (m_buf == MASTER) begin
            e.f = 1'b1; m_prog = 0;
         end else begin
            m_cand = m_buf; m_prog = 2; e.lat = 0;
         end
      end else if (m_prog == 2) begin
         if (m_buf == m_cand) begin
            e.p = 1'b1; model_store();
         end else e.f = 1'b1;
         m_prog = 0;
      end else begin
         e.lat = SLOTS + 2; e.busy_n = SLOTS + 1;
         for (int i = 0; i < SLOTS; i++)
            if (m_valid[i] && m_slot[i] == m_buf) hit = 1;
         if (m_buf == MASTER) begin
            m_prog = 1; m_fails = 0;
         end else if (hit) begin
            e.p = 1'b1; m_locked = ~m_locked; m_fails = 0;
         end else begin
            e.f = 1'b1; count_fail(e.lo);
         end
      end
      m_buf = '0; m_cnt = 0;
      e.lk = m_locked;
      e.pm_after = (m_prog != 0);
      exp_q.push_back(e);
   endtask

   task automatic press(input logic [3:0] k);
      @(negedge hwclk);
      key = k; key_valid = 1'b1;
      @(negedge hwclk);
      key_valid = 1'b0;
      if (k <= 4'd9) begin
         m_buf = (m_buf << 4) | 24'(k);
         m_cnt = (m_cnt == DIGITS + 1) ? m_cnt : m_cnt + 1;
      end else if (k == KEY_STAR) begin
         m_buf = '0; m_cnt = 0;
      end
   endtask

   task automatic collect();
      exp_t e;
      int   ev = 0, busy_n = 0, pass_n = 0, fail_n = 0, lo_n = 0, both = 0, win;
      logic sp = 0, sf = 0, slk = 0, spm = 0, slo = 0;
      e = exp_q.pop_front();
      win = e.lo ? LOCKOUT_CYC + SLOTS + 12 : SLOTS + 6;
      for (int k = 1; k <= win; k++) begin
         if (ev == 0 && (pass || fail || prog_mode !== e.pm_before)) begin
            ev = k; sp = pass; sf = fail; slk = locked; spm = prog_mode; slo = lockout;
         end
         if (busy) busy_n++;
         if (pass) pass_n++;
         if (fail) fail_n++;
         if (lockout) lo_n++;
         if (pass && fail) both++;
         // Keys hammered during lockout must be dropped.
         if (lockout) begin key = 4'd7; key_valid = 1'b1; end
         else key_valid = 1'b0;
         @(negedge hwclk);
      end
      key_valid = 1'b0;
      vectors++;
      if (ev !== e.lat) begin miscompares++; $display("FAIL %s latency: got %0d want %0d", e.name, ev, e.lat); end
      if (e.lat != 0) begin
         vectors++;
         if ({sp, sf, slk, spm, slo} !== {e.p, e.f, e.lk, e.pm_after, e.lo}) begin
            miscompares++;
            $display("FAIL %s event {pass,fail,locked,prog,lockout}: got %b want %b",
                     e.name, {sp, sf, slk, spm, slo}, {e.p, e.f, e.lk, e.pm_after, e.lo});
         end
      end
      vectors++;
      if (busy_n !== e.busy_n) begin miscompares++; $display("FAIL %s busy_cycles: got %0d want %0d", e.name, busy_n, e.busy_n); end
      vectors++;
      if (pass_n !== int'(e.p) || fail_n !== int'(e.f)) begin
         miscompares++;
         $display("FAIL %s pulse_count pass/fail: got %0d/%0d want %0d/%0d", e.name, pass_n, fail_n, e.p, e.f);
      end
      vectors++;
      if (lo_n !== (e.lo ? LOCKOUT_CYC : 0)) begin miscompares++; $display("FAIL %s lockout_cycles: got %0d want %0d", e.name, lo_n, e.lo ? LOCKOUT_CYC : 0); end
      vectors++;
      if (both !== 0) begin miscompares++; $display("FAIL %s pass_and_fail_together: got %0d cycles want 0", e.name, both); end
      vectors++;
      if ({locked, prog_mode, n_digits} !== {e.lk, e.pm_after, 4'd0}) begin
         miscompares++;
         $display("FAIL %s settled {locked,prog,n_digits}: got %b/%b/%0d want %b/%b/0",
                  e.name, locked, prog_mode, n_digits, e.lk, e.pm_after);
      end
   endtask

   task automatic hash(input string name);
      model_hash(name);
      press(KEY_HASH);
      collect();
   endtask

   task automatic enter(input logic [23:0] code, input string name);
      for (int i = DIGITS - 1; i >= 0; i--) press(code[4*i +: 4]);
      hash(name);
   endtask

   task automatic enrol(input logic [23:0] code, input string name);
      enter(MASTER, {name, "_master"});
      enter(code, {name, "_new"});
      enter(code, {name, "_confirm"});
   endtask

   task automatic check_digits(input int want, input string name);
      vectors++;
      if (n_digits !== 4'(want)) begin miscompares++; $display("FAIL %s n_digits: got %0d want %0d", name, n_digits, want); end
   endtask

   task automatic test_reset();
      model_reset();
      resetN = 1'b0;
      repeat (3) @(negedge hwclk);
      vectors++;
      if ({locked, pass, fail, prog_mode, lockout, busy, n_digits} !== {6'b100000, 4'd0}) begin
         miscompares++;
         $display("FAIL reset_state: got %b want 1000000000", {locked, pass, fail, prog_mode, lockout, busy, n_digits});
      end
      resetN = 1'b1;
      @(negedge hwclk);
   endtask

   task automatic test_enrol_first();
      enter(MASTER, "first_master");
      enter(24'h123456, "first_new");
      enter(24'h123456, "first_confirm");
   endtask

   task automatic test_toggle();
      enter(24'h123456, "unlock");
      enter(24'h123456, "relock");
   endtask

   task automatic test_entry_errors();
      press(4'd1); check_digits(1, "short_d1");
      press(4'd2); check_digits(2, "short_d2");
      hash("short_entry");
      for (int i = 1; i <= 8; i++) press(4'(i % 10));
      check_digits(DIGITS + 1, "overflow_sat");
      hash("long_entry");
      enter(24'h123456, "clear_fails");
      press(4'd1); press(4'd2); press(4'd3);
      check_digits(3, "star_pre");
      press(KEY_STAR);
      check_digits(0, "star_clear");
      press(4'd13); check_digits(0, "ignored_key");
   endtask

   task automatic test_lockout();
      enter(24'h000000, "wrong_1");
      enter(24'h000000, "wrong_2");
      enter(24'h000000, "wrong_3_lockout");
      enter(24'h123456, "after_lockout");
   endtask

   task automatic test_replace();
      enrol(24'h111111, "e1");
      enrol(24'h222222, "e2");
      enrol(24'h333333, "e3");
      enrol(24'h444444, "e4_replace");
      enter(24'h123456, "old_slot0");
      enter(24'h444444, "new_slot0");
      enrol(24'h222222, "dup");
      enrol(24'h555555, "e5_replace");
      enter(24'h111111, "old_slot1");
      enter(24'h333333, "kept_slot2");
   endtask

   task automatic test_prog_errors();
      enter(MASTER, "pm_master");
      enter(MASTER, "pm_cand_is_master");
      enter(MASTER, "pc_master");
      enter(24'h121212, "pc_new");
      enter(24'h343434, "pc_mismatch");
      enter(MASTER, "ps_master");
      press(4'd1); press(4'd2); press(KEY_STAR);
      vectors++;
      if ({prog_mode, n_digits} !== {1'b1, 4'd0}) begin
         miscompares++; $display("FAIL prog_star: got prog=%b n=%0d want prog=1 n=0", prog_mode, n_digits);
      end
      press(4'd1); press(4'd2);
      hash("prog_short");
      enter(24'h000000, "post_prog_wrong_1");
      enter(24'h000000, "post_prog_wrong_2");
      enter(24'h333333, "post_prog_clear");
   endtask

   task automatic test_reset_mid_check();
      int pulses = 0;
      for (int i = DIGITS - 1; i >= 0; i--) press(4'h4);
      press(KEY_HASH);
      @(negedge hwclk);
      #1 resetN = 1'b0;
      #1;
      vectors++;
      if ({locked, busy, prog_mode, lockout, pass, fail, n_digits} !== {6'b100000, 4'd0}) begin
         miscompares++;
         $display("FAIL reset_mid_check: got %b want 1000000000", {locked, busy, prog_mode, lockout, pass, fail, n_digits});
      end
      @(negedge hwclk);
      resetN = 1'b1;
      for (int k = 0; k < SLOTS + 6; k++) begin
         if (pass || fail) pulses++;
         @(negedge hwclk);
      end
      vectors++;
      if (pulses !== 0) begin miscompares++; $display("FAIL reset_no_pulse: got %0d pulses want 0", pulses); end
      model_reset();
      enter(24'h444444, "after_reset_rejected");
   endtask

   initial begin
      test_reset();
      test_enrol_first();
      test_toggle();
      test_entry_errors();
      test_lockout();
      test_replace();
      test_prog_errors();
      test_reset_mid_check();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
